// File: rtl/mm_bus_master.sv
// mm_bus_master: turns host valid/ready commands into single-beat bus accesses and
// periodically polls the status (STATUS_ADDR) and error-count (ERR_ADDR) registers.
// Optional macro ERR_ALARM_EN adds per-channel error alarms (err_alarm, alarm_irq).
module mm_bus_master #(
    parameter int         READ_LATENCY = 2,
    parameter logic [7:0] STATUS_ADDR  = 8'h01,
    parameter logic [7:0] ERR_ADDR     = 8'h02,
    parameter logic [7:0] ERR_THRESH   = 8'd200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        mm_write_en,
    output logic        mm_read_en,
    output logic [7:0]  mm_addr,
    output logic [31:0] mm_wdata,
    input  logic [31:0] mm_rdata,
    input  logic        poll_en,
    input  logic [19:0] poll_period,
    output logic [1:0]  active_ch,
    output logic [3:0]  presence,
    output logic [31:0] err_snap,
    output logic        poll_done,
`ifdef ERR_ALARM_EN
    output logic [3:0]  err_alarm,
    output logic        alarm_irq,
`endif
    output logic        busy
);

    localparam logic [3:0] LAT = 4'(READ_LATENCY);

    typedef enum logic [3:0] {
        IDLE, WR, RD, WAIT, RESP, P_RD1, P_WAIT1, P_RD2, P_WAIT2, P_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [19:0] poll_cnt_reg, poll_cnt_next;
    logic        pending_reg, pending_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;

    logic cmd_accept;
    logic poll_on;
    logic poll_expire;
    logic lat_done;
    logic start_poll;
    logic host_capture;
    logic status_capture;
    logic err_capture;

    assign cmd_accept     = (state_reg == IDLE) && !pending_reg && cmd_valid && cmd_ready;
    assign poll_on        = poll_en && (poll_period != 20'd0);
    assign poll_expire    = poll_on && (poll_cnt_reg == poll_period - 20'd1);
    assign lat_done       = (wait_cnt_reg == LAT);
    assign host_capture   = (state_reg == WAIT) && lat_done;
    assign status_capture = (state_reg == P_WAIT1) && lat_done;
    assign err_capture    = (state_reg == P_WAIT2) && lat_done;

    always_comb begin
        state_next    = state_reg;
        poll_cnt_next = poll_cnt_reg;
        pending_next  = pending_reg;
        wait_cnt_next = wait_cnt_reg;
        start_poll    = 1'b0;

        if (!poll_on) begin
            poll_cnt_next = 20'd0;
            pending_next  = 1'b0;
        end else if (poll_expire) begin
            poll_cnt_next = 20'd0;
            pending_next  = 1'b1;
        end else begin
            poll_cnt_next = poll_cnt_reg + 20'd1;
        end

        case (state_reg)
            IDLE: begin
                if (pending_reg) begin
                    state_next = P_RD1;
                    start_poll = 1'b1;
                end else if (cmd_accept) begin
                    state_next = cmd_write ? WR : RD;
                end
            end
            WR:   state_next = RESP;
            RD: begin
                state_next    = WAIT;
                wait_cnt_next = 4'd1;
            end
            WAIT: begin
                if (lat_done) state_next = RESP;
                else          wait_cnt_next = wait_cnt_reg + 4'd1;
            end
            RESP: state_next = IDLE;
            P_RD1: begin
                state_next    = P_WAIT1;
                wait_cnt_next = 4'd1;
            end
            P_WAIT1: begin
                if (lat_done) state_next = P_RD2;
                else          wait_cnt_next = wait_cnt_reg + 4'd1;
            end
            P_RD2: begin
                state_next    = P_WAIT2;
                wait_cnt_next = 4'd1;
            end
            P_WAIT2: begin
                if (lat_done) state_next = P_DONE;
                else          wait_cnt_next = wait_cnt_reg + 4'd1;
            end
            P_DONE: begin
                // An expiry that landed mid-sequence chains straight into the next poll.
                if (pending_reg) begin
                    state_next = P_RD1;
                    start_poll = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // The request is consumed as the sequence starts so that an expiry during the
        // sequence is remembered; a same-cycle expiry keeps it set.
        if (start_poll && !poll_expire) pending_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            poll_cnt_reg <= 20'd0;
            pending_reg  <= 1'b0;
            wait_cnt_reg <= 4'd0;
            cmd_ready    <= 1'b0;
            busy         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'd0;
            mm_write_en  <= 1'b0;
            mm_read_en   <= 1'b0;
            mm_addr      <= 8'd0;
            mm_wdata     <= 32'd0;
            poll_done    <= 1'b0;
            active_ch    <= 2'd0;
            presence     <= 4'd0;
            err_snap     <= 32'd0;
        end else begin
            state_reg    <= state_next;
            poll_cnt_reg <= poll_cnt_next;
            pending_reg  <= pending_next;
            wait_cnt_reg <= wait_cnt_next;
            cmd_ready    <= (state_next == IDLE) && !pending_next;
            busy         <= (state_next != IDLE);
            mm_write_en  <= (state_next == WR);
            mm_read_en   <= (state_next == RD) || (state_next == P_RD1) || (state_next == P_RD2);
            rsp_valid    <= (state_next == RESP);
            poll_done    <= (state_next == P_DONE);

            if (cmd_accept) begin
                mm_addr <= cmd_addr;
                if (cmd_write) mm_wdata <= cmd_wdata;
            end else if (state_next == P_RD1) begin
                mm_addr <= STATUS_ADDR;
            end else if (state_next == P_RD2) begin
                mm_addr <= ERR_ADDR;
            end

            if (state_reg == WR)   rsp_rdata <= 32'd0;
            else if (host_capture) rsp_rdata <= mm_rdata;

            if (status_capture) begin
                active_ch <= mm_rdata[1:0];
                presence  <= mm_rdata[5:2];
            end
            if (err_capture) err_snap <= mm_rdata;
        end
    end

`ifdef ERR_ALARM_EN
    logic [3:0] alarm_new;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_alarm_cmp
            assign alarm_new[gi] = (mm_rdata[8*gi +: 8] > ERR_THRESH);
        end
    endgenerate

    // Computed at the capture edge so the irq lands in the P_DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_alarm <= 4'd0;
            alarm_irq <= 1'b0;
        end else if (err_capture) begin
            err_alarm <= alarm_new;
            alarm_irq <= |(alarm_new & ~err_alarm);
        end else begin
            alarm_irq <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/mm_bus_master.md
Name: mm_bus_master

Overview:
- Initiator side of the main_control memory-mapped register port (mm_write_en / mm_read_en / mm_addr / mm_wdata / mm_rdata).
- Turns host commands (valid/ready) into single-beat bus writes and reads, and returns one response per command.
- Also runs an autonomous status poller. The poller periodically reads address 0x01 (active channel / signal presence) and address 0x02 (per-channel error counts) into shadow outputs.
- Sits between the host/CPU-side logic and main_control.

Parameters:
READ_LATENCY, 2, cycles from the mm_read_en cycle to the capture edge of mm_rdata; legal range 1..15
STATUS_ADDR, 8'h01, address of the active-channel/presence register
ERR_ADDR, 8'h02, address of the packed error-count register
ERR_THRESH, 8'd200, per-channel alarm threshold (used only with ERR_ALARM_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  host command valid
cmd_ready  out  1  master can accept a command this cycle
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  8  command address
cmd_wdata  in  32  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  read data; 0 for write responses
mm_write_en  out  1  bus write strobe
mm_read_en  out  1  bus read strobe
mm_addr  out  8  bus address
mm_wdata  out  32  bus write data
mm_rdata  in  32  bus read data
poll_en  in  1  enable autonomous polling
poll_period  in  20  poll interval in cycles; 0 = polling disabled
active_ch  out  2  shadow of status bits [1:0]
presence  out  4  shadow of status bits [5:2]
err_snap  out  32  shadow of error-count word (ch1 = [7:0] … ch4 = [31:24])
poll_done  out  1  one-cycle pulse when a poll pair has completed
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Single clock domain.
- Synchronous active-high rst: FSM returns to IDLE and the poll counter and poll_pending are cleared.
- All outputs are registered and reset to 0.
- Any in-flight transaction is dropped on reset: no rsp_valid and no shadow update.
- FSM states: IDLE, WR, RD, WAIT, RESP, P_RD1, P_WAIT1, P_RD2, P_WAIT2, P_DONE.
- cmd_ready = (state == IDLE) && !poll_pending.
- A command is accepted at an edge where cmd_valid && cmd_ready. Address and data are registered on accept.
- Write path:
  - Cycle after accept: WR, with mm_write_en = 1 for exactly one cycle, mm_addr and mm_wdata driven.
  - Next cycle: RESP, with rsp_valid = 1 and rsp_rdata = 0.
  - Then IDLE. Command-to-response latency is 2 cycles.
- Read path:
  - Cycle after accept: RD, with mm_read_en = 1 for one cycle. Call this cycle 0.
  - WAIT counts cycles; mm_rdata is captured at the edge ending cycle READ_LATENCY.
  - Cycle READ_LATENCY+1: RESP, with rsp_valid = 1 and rsp_rdata = the captured value.
- mm_addr holds its last value between transactions. mm_wdata changes only on write issue.
- mm_write_en and mm_read_en are never high in the same cycle.
- Poll timer:
  - Counts while poll_en && poll_period != 0.
  - When it reaches poll_period-1 it wraps to 0 and sets poll_pending.
  - poll_en low or poll_period == 0 clears both the counter and poll_pending. An already-started poll sequence still completes.
- Arbitration in IDLE: poll_pending has priority over a host command. cmd_ready is already low while poll_pending is set, so a host command cannot be accepted in that cycle.
- Poll sequence (atomic; cmd_ready stays low throughout):
  - P_RD1: read STATUS_ADDR.
  - P_WAIT1: capture; active_ch <= rdata[1:0], presence <= rdata[5:2].
  - P_RD2: read ERR_ADDR.
  - P_WAIT2: capture; err_snap <= rdata.
  - P_DONE: poll_done = 1, poll_pending cleared, return to IDLE.
- Poll sequence duration: 2*(READ_LATENCY+1)+1 cycles.
- A timer expiry during a poll sequence sets poll_pending again; the next sequence starts immediately after P_DONE.
- Host commands never update the shadow outputs, even if they target STATUS_ADDR or ERR_ADDR.

Optional Feature:
Macro ERR_ALARM_EN.
- Defined: adds output err_alarm [3:0].
  - Bit i is updated only in P_WAIT2 to (err_snap byte i > ERR_THRESH). It holds otherwise and resets to 0.
  - Adds output alarm_irq, a one-cycle pulse in P_DONE when any err_alarm bit transitions 0 to 1.
- Not defined: neither port exists, and no comparators are built.

Test Plan:
- Reset, then write cmd (addr 8'h00, wdata 32'h0001_E0B5): mm_write_en high exactly 1 cycle, one cycle after accept, with mm_addr = 8'h00 and mm_wdata = 32'h0001_E0B5. rsp_valid 2 cycles after accept, rsp_rdata = 0.
- READ_LATENCY = 2, read cmd addr 8'h01, slave returns 32'h0000_003D: mm_read_en 1 cycle; rsp_valid in cycle 3 relative to the read_en cycle (cycle 0); rsp_rdata = 32'h3D; active_ch and presence unchanged.
- poll_en = 1, poll_period = 30, slave status 32'h3D and err 32'h0C_81_24_09: poll_done every 30 cycles; active_ch = 2'b01, presence = 4'b1111, err_snap = 32'h0C812409; two reads per poll at addresses 01 then 02.
- Host cmd_valid held in the cycle poll_pending sets: cmd_ready low through the poll sequence; command accepted the cycle after P_DONE; exactly one response.
- rst asserted in WAIT of a host read: no rsp_valid; all outputs 0 next cycle; cmd_ready = 1 the cycle after rst deasserts.
- ERR_ALARM_EN defined, ERR_THRESH = 200, err word 32'h00_00_C9_10: err_alarm = 4'b0010; alarm_irq pulses once; it does not pulse again on the next identical poll.
